// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared floating-point types, flag indices and canonical NaN helper
package fp_pkg;

   typedef enum logic [1:0] {
      FP_ZERO,
      FP_NORM,
      FP_INF,
      FP_NAN
   } fp_class_t;

   // bit positions inside the {NV, OF, UF, NX} flag nibble
   localparam int FLG_NV = 3;
   localparam int FLG_OF = 2;
   localparam int FLG_UF = 1;
   localparam int FLG_NX = 0;

   // widest word the NaN helper can build; callers slice the low bits they need
   localparam int QNAN_MAX_W = 128;

   // canonical quiet NaN: sign 0, exponent all ones, mantissa MSB only
   function automatic logic [QNAN_MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
      logic [QNAN_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < exp_w; i++) begin
         r[man_w + i] = 1'b1;
      end
      r[man_w - 1] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/fp_mul_pipe_if.sv
// rtl/fp_mul_pipe_if.sv - operand/result handshake bundle (out_flags present with FP_MUL_FLAGS_EN)
interface fp_mul_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     in_a;
   logic [W-1:0]     in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     out_p;
   logic [TAG_W-1:0] out_tag;
`ifdef FP_MUL_FLAGS_EN
   logic [3:0]       out_flags;

   modport master (
      output in_valid, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_p, out_tag, out_flags
   );
   modport slave (
      input  in_valid, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_p, out_tag, out_flags
   );
`else
   modport master (
      output in_valid, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_p, out_tag
   );
   modport slave (
      input  in_valid, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_p, out_tag
   );
`endif

endinterface

// File: rtl/fp_mul_round.sv
// rtl/fp_mul_round.sv - normalise, round-to-nearest-even, range check and pack (flags with FP_MUL_FLAGS_EN)
module fp_mul_round
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
)(
   input  logic                      sign,
   input  fp_class_t                 cls_a,
   input  fp_class_t                 cls_b,
   input  logic signed [EXP_W+1:0]   exp_in,
   input  logic [2*MAN_W+1:0]        prod,
`ifdef FP_MUL_FLAGS_EN
   output logic [3:0]                flags,
`endif
   output logic [EXP_W+MAN_W:0]      p
);
   localparam int PW = 2 * MAN_W + 2;
   localparam int EW = EXP_W + 2;
   localparam logic signed [EW-1:0] EXP_ONES = {2'b00, {EXP_W{1'b1}}};
   localparam logic [QNAN_MAX_W-1:0] QNAN_FULL = fp_qnan(EXP_W, MAN_W);

   logic                 hi;
   logic [MAN_W-1:0]     man;
   logic                 guard;
   logic                 sticky;
   logic                 inc;
   logic [MAN_W:0]       man_r;
   logic signed [EW-1:0] exp_n;
   logic signed [EW-1:0] exp_f;
   logic                 ovf;
   logic                 unf;
   logic                 is_nan;
   logic                 is_inf;
   logic                 is_zero;

   // normalise on the product MSB, round to nearest even, then resolve specials by priority
   always_comb begin
      hi     = prod[PW-1];
      man    = hi ? prod[PW-2 -: MAN_W] : prod[PW-3 -: MAN_W];
      guard  = hi ? prod[MAN_W] : prod[MAN_W-1];
      sticky = hi ? |prod[MAN_W-1:0] : |prod[MAN_W-2:0];
      inc    = guard & (sticky | man[0]);
      man_r  = {1'b0, man} + {{MAN_W{1'b0}}, inc};
      exp_n  = exp_in + $signed({{(EW-1){1'b0}}, hi});
      exp_f  = exp_n + $signed({{(EW-1){1'b0}}, man_r[MAN_W]});
      ovf    = exp_f >= EXP_ONES;
      unf    = exp_f[EW-1] || (exp_f == '0);

      is_nan  = (cls_a == FP_NAN) || (cls_b == FP_NAN) ||
                (cls_a == FP_INF && cls_b == FP_ZERO) ||
                (cls_a == FP_ZERO && cls_b == FP_INF);
      is_inf  = (cls_a == FP_INF) || (cls_b == FP_INF);
      is_zero = (cls_a == FP_ZERO) || (cls_b == FP_ZERO);

      p = {sign, exp_f[EXP_W-1:0], man_r[MAN_W-1:0]};
`ifdef FP_MUL_FLAGS_EN
      flags = 4'b0000;
`endif
      if (is_nan) begin
         p = QNAN_FULL[EXP_W+MAN_W:0];
`ifdef FP_MUL_FLAGS_EN
         flags[FLG_NV] = 1'b1;
`endif
      end else if (is_inf) begin
         p = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (is_zero) begin
         p = {sign, {(EXP_W+MAN_W){1'b0}}};
      end else if (ovf) begin
         p = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_MUL_FLAGS_EN
         flags[FLG_OF] = 1'b1;
         flags[FLG_NX] = 1'b1;
`endif
      end else if (unf) begin
         p = {sign, {(EXP_W+MAN_W){1'b0}}};
`ifdef FP_MUL_FLAGS_EN
         flags[FLG_UF] = 1'b1;
         flags[FLG_NX] = 1'b1;
`endif
      end else begin
`ifdef FP_MUL_FLAGS_EN
         flags[FLG_NX] = guard | sticky;
`endif
      end
   end

endmodule

// File: rtl/fp_mul_pipe.sv
// rtl/fp_mul_pipe.sv - three-stage pipelined FP multiplier with valid/ready (flags with FP_MUL_FLAGS_EN)
module fp_mul_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23,
   parameter int TAG_W = 4
)(
   input  logic         clk,
   input  logic         rst,
   fp_mul_pipe_if.slave bus
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int SW = MAN_W + 1;
   localparam int EW = EXP_W + 2;
   localparam logic [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);

   function automatic fp_class_t classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] m);
      if (e == '0) return FP_ZERO;
      if (&e) return (m == '0) ? FP_INF : FP_NAN;
      return FP_NORM;
   endfunction

   logic                 en;
   logic [EXP_W-1:0]     exp_a, exp_b;
   logic [MAN_W-1:0]     man_a, man_b;

   logic                 s1_valid, s1_sign;
   fp_class_t            s1_cls_a, s1_cls_b;
   logic [SW-1:0]        s1_sig_a, s1_sig_b;
   logic signed [EW-1:0] s1_exp;
   logic [TAG_W-1:0]     s1_tag;

   logic                 s2_valid, s2_sign;
   fp_class_t            s2_cls_a, s2_cls_b;
   logic [2*SW-1:0]      s2_prod;
   logic signed [EW-1:0] s2_exp;
   logic [TAG_W-1:0]     s2_tag;

   logic                 out_valid_q;
   logic [W-1:0]         out_p_q, round_p;
   logic [TAG_W-1:0]     out_tag_q;
`ifdef FP_MUL_FLAGS_EN
   logic [3:0]           out_flags_q, round_flags;
`endif

   assign exp_a = bus.in_a[W-2:MAN_W];
   assign exp_b = bus.in_b[W-2:MAN_W];
   assign man_a = bus.in_a[MAN_W-1:0];
   assign man_b = bus.in_b[MAN_W-1:0];

   // one global advance: the whole pipe moves unless a result is stuck at the output
   assign en           = !out_valid_q || bus.out_ready;
   assign bus.in_ready = en;

   // stage 1: classify operands, build significands, add biased exponents
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_sign  <= 1'b0;
         s1_cls_a <= FP_ZERO;
         s1_cls_b <= FP_ZERO;
         s1_sig_a <= '0;
         s1_sig_b <= '0;
         s1_exp   <= '0;
         s1_tag   <= '0;
      end else if (en) begin
         s1_valid <= bus.in_valid;
         s1_sign  <= bus.in_a[W-1] ^ bus.in_b[W-1];
         s1_cls_a <= classify(exp_a, man_a);
         s1_cls_b <= classify(exp_b, man_b);
         s1_sig_a <= {1'b1, man_a};
         s1_sig_b <= {1'b1, man_b};
         s1_exp   <= $signed({2'b00, exp_a} + {2'b00, exp_b} - BIAS);
         s1_tag   <= bus.in_tag;
      end
   end

   // stage 2: full-width significand product
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid <= 1'b0;
         s2_sign  <= 1'b0;
         s2_cls_a <= FP_ZERO;
         s2_cls_b <= FP_ZERO;
         s2_prod  <= '0;
         s2_exp   <= '0;
         s2_tag   <= '0;
      end else if (en) begin
         s2_valid <= s1_valid;
         s2_sign  <= s1_sign;
         s2_cls_a <= s1_cls_a;
         s2_cls_b <= s1_cls_b;
         s2_prod  <= {{SW{1'b0}}, s1_sig_a} * {{SW{1'b0}}, s1_sig_b};
         s2_exp   <= s1_exp;
         s2_tag   <= s1_tag;
      end
   end

   fp_mul_round #(
      .EXP_W (EXP_W),
      .MAN_W (MAN_W)
   ) u_round (
      .sign   (s2_sign),
      .cls_a  (s2_cls_a),
      .cls_b  (s2_cls_b),
      .exp_in (s2_exp),
      .prod   (s2_prod),
`ifdef FP_MUL_FLAGS_EN
      .flags  (round_flags),
`endif
      .p      (round_p)
   );

   // stage 3: register the packed result; held while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         out_p_q     <= '0;
         out_tag_q   <= '0;
`ifdef FP_MUL_FLAGS_EN
         out_flags_q <= '0;
`endif
      end else if (en) begin
         out_valid_q <= s2_valid;
         out_p_q     <= round_p;
         out_tag_q   <= s2_tag;
`ifdef FP_MUL_FLAGS_EN
         out_flags_q <= round_flags;
`endif
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_p     = out_p_q;
   assign bus.out_tag   = out_tag_q;
`ifdef FP_MUL_FLAGS_EN
   assign bus.out_flags = out_flags_q;
`endif

endmodule
